food_plotter: RTL

//  Framebuffer writer for the food block in the snake game.
//  - On request, erases the previously drawn food pixels, then draws the current
//    N_PIX food pixels from the food generator.
//  - Then pulses write_done, which advances the food generator to its next position.
//  - Sits between the food generator and the VGA framebuffer write port.

---
 rtl/food_plotter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/food_plotter.sv
`default_nettype none
// ============================================================================
//  Module   : food_plotter
//  Purpose  : Framebuffer writer for the snake-game food block. On a start
//             request it snapshots the generator's food pixels, erases the
//             previously drawn food (if any) in the background colour, draws
//             the new food in the food colour, then pulses write_done so the
//             generator can move on to its next position.
//  Ports    :
//    clk         in   system clock
//    reset       in   synchronous, active-high reset
//    start       in   redraw request, only sampled while idle
//    foodx       in   [X_W-1:0] x N_PIX food pixel x coordinates
//    foody       in   [Y_W-1:0] x N_PIX food pixel y coordinates
//    px_x        out  framebuffer write x
//    px_y        out  framebuffer write y
//    px_color    out  framebuffer write colour
//    px_we       out  framebuffer write valid
//    px_ready    in   framebuffer accepts the write when px_we & px_ready
//    busy        out  high whenever not idle
//    write_done  out  one-cycle pulse when a redraw completes
//  Revision : 1.0 - initial release
// ============================================================================
module food_plotter #(
  parameter int                  N_PIX    = 9,
  parameter int                  X_W      = 10,
  parameter int                  Y_W      = 9,
  parameter int                  COLOR_W  = 3,
  parameter int                  SCREEN_W = 640,
  parameter int                  SCREEN_H = 480,
  parameter logic [COLOR_W-1:0]  FOOD_CLR = 3'b100,
  parameter logic [COLOR_W-1:0]  BG_CLR   = 3'b000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [X_W-1:0]     foodx [N_PIX],
  input  logic [Y_W-1:0]     foody [N_PIX],
  output logic [X_W-1:0]     px_x,
  output logic [Y_W-1:0]     px_y,
  output logic [COLOR_W-1:0] px_color,
  output logic               px_we,
  input  logic               px_ready,
  output logic               busy,
  output logic               write_done
);

  localparam int IDX_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIX - 1);

  // One extra bit so a screen dimension equal to 2**W still compares correctly.
  localparam logic [X_W:0] SCR_W_C = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H_C = (Y_W + 1)'(SCREEN_H);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ERASE = 2'd1,
    S_DRAW  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             prev_valid_q;

  logic [X_W-1:0]   cur_x_q  [N_PIX];
  logic [Y_W-1:0]   cur_y_q  [N_PIX];
  logic [X_W-1:0]   prev_x_q [N_PIX];
  logic [Y_W-1:0]   prev_y_q [N_PIX];

  logic             snap;
  logic             commit;
  logic             step;
  logic [X_W-1:0]   sel_x;
  logic [Y_W-1:0]   sel_y;
  logic             in_bounds;

  // Erase walks the previously drawn set, draw walks the fresh snapshot.
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    if (state_q == S_ERASE) begin
      sel_x = prev_x_q[idx_q];
      sel_y = prev_y_q[idx_q];
    end else begin
      sel_x = cur_x_q[idx_q];
      sel_y = cur_y_q[idx_q];
    end
  end

  assign in_bounds = ({1'b0, sel_x} < SCR_W_C) && ({1'b0, sel_y} < SCR_H_C);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    snap       = 1'b0;
    commit     = 1'b0;
    step       = 1'b0;
    px_x       = '0;
    px_y       = '0;
    px_color   = '0;
    px_we      = 1'b0;
    write_done = 1'b0;
    busy       = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          snap    = 1'b1;
          idx_d   = '0;
          state_d = prev_valid_q ? S_ERASE : S_DRAW;
        end
      end

      S_ERASE, S_DRAW: begin
        px_x     = sel_x;
        px_y     = sel_y;
        px_color = (state_q == S_ERASE) ? BG_CLR : FOOD_CLR;
        px_we    = in_bounds;
        // An off-screen pixel costs exactly one idle cycle; an on-screen
        // pixel holds until the framebuffer accepts it.
        step     = in_bounds ? px_ready : 1'b1;
        if (step) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = (state_q == S_ERASE) ? S_DRAW : S_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      S_DONE: begin
        write_done = 1'b1;
        commit     = 1'b1;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (commit) begin
        prev_valid_q <= 1'b1;
      end
    end
  end

  // Coordinate storage needs no reset: prev_valid_q gates any use of prev,
  // and cur is always reloaded before a draw.
  always_ff @(posedge clk) begin
    if (snap) begin
      cur_x_q <= foodx;
      cur_y_q <= foody;
    end
    if (commit) begin
      prev_x_q <= cur_x_q;
      prev_y_q <= cur_y_q;
    end
  end

endmodule
`default_nettype wire
